// File: rtl/dc_bsp_pkg.sv
// Board support constants shared by the ASP interrupt controller.
package dc_bsp_pkg;

  // IRQ source usage and host interrupt line count.
  localparam int unsigned BSP_AVMM_NUM_IRQ_USED   = 3;
  localparam int unsigned BSP_NUM_INTERRUPT_LINES = 4;

  // IRQ source bit positions.
  localparam int unsigned BSP_IRQ_DMA_0  = 0;
  localparam int unsigned BSP_IRQ_KERNEL = 1;
  localparam int unsigned BSP_IRQ_DMA_1  = 2;

  // Interrupt controller register word addresses.
  localparam int unsigned IRQ_REG_PENDING   = 0;
  localparam int unsigned IRQ_REG_MASK      = 1;
  localparam int unsigned IRQ_REG_RAW       = 2;
  localparam int unsigned IRQ_REG_SENT      = 3;
  localparam int unsigned IRQ_REG_REQ_COUNT = 4;

  // Request FSM states.
  typedef enum logic {
    StIdle,
    StReq
  } irq_fsm_e;

endpackage

// File: rtl/asp_irq_rr_arbiter.sv
// Combinational round-robin select: lowest eligible line above i_last, else lowest overall.
module asp_irq_rr_arbiter
  import dc_bsp_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = BSP_AVMM_NUM_IRQ_USED,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_IRQ-1:0]  i_eligible,
  input  logic [ID_WIDTH-1:0] i_last,
  output logic [ID_WIDTH-1:0] o_grant,
  output logic                o_any
);

  logic                w_hi_any;
  logic                w_lo_any;
  logic [ID_WIDTH-1:0] w_hi_grant;
  logic [ID_WIDTH-1:0] w_lo_grant;

  // Scan downward so the last hit in each half is the lowest index in that half.
  always_comb begin
    w_hi_any   = 1'b0;
    w_lo_any   = 1'b0;
    w_hi_grant = '0;
    w_lo_grant = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (i_eligible[i]) begin
        if (i > int'(i_last)) begin
          w_hi_any   = 1'b1;
          w_hi_grant = ID_WIDTH'(i);
        end else begin
          w_lo_any   = 1'b1;
          w_lo_grant = ID_WIDTH'(i);
        end
      end
    end
    o_any   = w_hi_any | w_lo_any;
    o_grant = w_hi_any ? w_hi_grant : w_lo_grant;
  end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: edge-latched pending, host mask, round-robin valid/ready requests,
// and a 64-bit AVMM register slave.
module asp_irq_ctrl
  import dc_bsp_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = BSP_AVMM_NUM_IRQ_USED,
  parameter int unsigned NUM_LINES  = BSP_NUM_INTERRUPT_LINES,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IRQ-1:0]           irq_in,
  input  logic [ADDR_WIDTH-1:0]        avmm_address,
  input  logic                         avmm_read,
  input  logic                         avmm_write,
  input  logic [63:0]                  avmm_writedata,
  input  logic [7:0]                   avmm_byteenable,
  output logic [63:0]                  avmm_readdata,
  output logic                         avmm_readdatavalid,
  output logic                         avmm_waitrequest,
  output logic                         irq_valid,
  output logic [$clog2(NUM_LINES)-1:0] irq_id,
  input  logic                         irq_ready
);

  localparam int unsigned IdW = $clog2(NUM_LINES);

  logic [NUM_IRQ-1:0] r_irq_in_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_sent;
  logic [NUM_IRQ-1:0] r_mask;
  logic [31:0]        r_req_count;
  irq_fsm_e           r_state;
  logic [IdW-1:0]     r_last;
  logic [IdW-1:0]     r_irq_id;
  logic               r_irq_valid;
  logic [63:0]        r_readdata;
  logic               r_readdatavalid;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_bit_be;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_mask_wr;
  logic [NUM_IRQ-1:0] w_acc;
  logic [NUM_IRQ-1:0] w_pending_d;
  logic [NUM_IRQ-1:0] w_sent_d;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [IdW-1:0]     w_grant;
  logic               w_any;
  logic               w_accept;
  logic [63:0]        w_rd_data;
  logic               w_unused;

  assign avmm_waitrequest   = 1'b0;
  assign irq_valid          = r_irq_valid;
  assign irq_id             = r_irq_id;
  assign avmm_readdata      = r_readdata;
  assign avmm_readdatavalid = r_readdatavalid;
  assign w_unused           = ^{avmm_writedata, avmm_byteenable};

  assign w_rise   = irq_in & ~r_irq_in_q;
  assign w_accept = r_irq_valid & irq_ready;

  // Per-bit write enables from byte enables, W1C/RW strobes and the accepted-line one-hot.
  always_comb begin
    w_bit_be = '0;
    w_acc    = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      w_bit_be[i] = avmm_byteenable[i / 8];
      w_acc[i]    = w_accept && (int'(r_irq_id) == i);
    end
    w_clr     = '0;
    w_mask_wr = '0;
    if (avmm_write && avmm_address == ADDR_WIDTH'(IRQ_REG_PENDING)) begin
      w_clr = w_bit_be & avmm_writedata[NUM_IRQ-1:0];
    end
    if (avmm_write && avmm_address == ADDR_WIDTH'(IRQ_REG_MASK)) begin
      w_mask_wr = w_bit_be;
    end
  end

  // A new rise beats a same-cycle clear; sent can never outlive its pending bit or a clear.
  assign w_pending_d = (r_pending & ~w_clr) | w_rise;
  assign w_sent_d    = (r_sent | w_acc) & ~w_clr & w_pending_d;
  assign w_eligible  = r_pending & ~r_mask & ~r_sent;

  asp_irq_rr_arbiter #(
    .NUM_IRQ  (NUM_IRQ),
    .ID_WIDTH (IdW)
  ) u_arbiter (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_grant    (w_grant),
    .o_any      (w_any)
  );

  // Source edge detect, pending/sent/mask state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_in_q <= '0;
      r_pending  <= '0;
      r_sent     <= '0;
      r_mask     <= '1;
    end else begin
      r_irq_in_q <= irq_in;
      r_pending  <= w_pending_d;
      r_sent     <= w_sent_d;
      r_mask     <= (r_mask & ~w_mask_wr) | (avmm_writedata[NUM_IRQ-1:0] & w_mask_wr);
    end
  end

  // Request FSM: issue one grant, hold it until accepted, then idle for a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
      r_last      <= IdW'(NUM_IRQ - 1);
      r_req_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_irq_id    <= w_grant;
            r_irq_valid <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          if (irq_ready) begin
            r_last      <= r_irq_id;
            r_req_count <= r_req_count + 32'd1;
            r_irq_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read mux; unmapped addresses and unused bits return 0.
  always_comb begin
    w_rd_data = '0;
    if (avmm_address == ADDR_WIDTH'(IRQ_REG_PENDING))   w_rd_data = 64'(r_pending);
    if (avmm_address == ADDR_WIDTH'(IRQ_REG_MASK))      w_rd_data = 64'(r_mask);
    if (avmm_address == ADDR_WIDTH'(IRQ_REG_RAW))       w_rd_data = 64'(irq_in);
    if (avmm_address == ADDR_WIDTH'(IRQ_REG_SENT))      w_rd_data = 64'(r_sent);
    if (avmm_address == ADDR_WIDTH'(IRQ_REG_REQ_COUNT)) w_rd_data = 64'(r_req_count);
  end

  // Fixed one-cycle read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= avmm_read;
      if (avmm_read) r_readdata <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: cycle table plus directed multi-cycle sequences.
module tb_asp_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  irq_in;
  logic [2:0]  avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic        irq_ready;

  int n_vec = 0;
  int n_bad = 0;
  int got_id[$];
  int got_at[$];

  asp_irq_ctrl u_dut (
    .clk                (clk),
    .reset              (reset),
    .irq_in             (irq_in),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .irq_valid          (irq_valid),
    .irq_id             (irq_id),
    .irq_ready          (irq_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  irq;
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [63:0] wd;
    logic [7:0]  be;
    logic        rdy;
    logic        ev;
    logic [1:0]  eid;
    logic        erdv;
    logic [63:0] erd;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [2:0] irq, logic rd, logic wr, logic [2:0] addr,
                              logic [63:0] wd, logic [7:0] be, logic rdy, logic ev,
                              logic [1:0] eid, logic erdv, logic [63:0] erd);
    vec_t v;
    v.irq = irq; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.be = be; v.rdy = rdy;
    v.ev = ev; v.eid = eid; v.erdv = erdv; v.erd = erd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be);
    avmm_address    = a;
    avmm_writedata  = d;
    avmm_byteenable = be;
    avmm_write      = 1'b1;
    step();
    avmm_write      = 1'b0;
    avmm_byteenable = '0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [63:0] exp);
    avmm_address = a;
    avmm_read    = 1'b1;
    step();
    avmm_read    = 1'b0;
    chk({name, " rdv"}, 64'(avmm_readdatavalid), 64'd1);
    chk(name, avmm_readdata, exp);
  endtask

  // Step for a number of cycles, recording every id seen with valid and the step it appeared on.
  task automatic collect(input int cycles);
    got_id.delete();
    got_at.delete();
    for (int c = 1; c <= cycles; c++) begin
      step();
      if (irq_valid) begin
        got_id.push_back(int'(irq_id));
        got_at.push_back(c);
      end
    end
  endtask

  task automatic wait_valid(input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      found = irq_valid;
    end
    chk({name, " valid within budget"}, 64'(found), 64'd1);
  endtask

  task automatic chk_order(input string name);
    chk({name, " count"}, 64'(got_id.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s id[%0d]", name, i),
          64'((i < got_id.size()) ? got_id[i] : -1), 64'(i));
      chk($sformatf("%s at[%0d]", name, i),
          64'((i < got_at.size()) ? got_at[i] : -1), 64'(2 + 2 * i));
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0;
    avmm_writedata = '0; avmm_byteenable = '0; irq_ready = 1'b0;

    //             irq  rd wr addr wd   be     rdy  ev eid rdv rdata
    tbl[0]  = mk(3'd0, 1, 0, 3'd1, 0,   8'h00, 0,   0, 0,  1, 64'h7);
    tbl[1]  = mk(3'd0, 1, 0, 3'd0, 0,   8'h00, 0,   0, 0,  1, 64'h0);
    tbl[2]  = mk(3'd2, 0, 0, 3'd0, 0,   8'h00, 0,   0, 0,  0, 64'h0);
    tbl[3]  = mk(3'd0, 0, 0, 3'd0, 0,   8'h00, 0,   0, 0,  0, 64'h0);
    tbl[4]  = mk(3'd0, 1, 0, 3'd0, 0,   8'h00, 0,   0, 0,  1, 64'h2);
    tbl[5]  = mk(3'd0, 1, 0, 3'd3, 0,   8'h00, 0,   0, 0,  1, 64'h0);
    tbl[6]  = mk(3'd0, 0, 1, 3'd0, 2,   8'h01, 0,   0, 0,  0, 64'h0);
    tbl[7]  = mk(3'd0, 0, 1, 3'd1, 0,   8'h01, 0,   0, 0,  0, 64'h0);
    tbl[8]  = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   0, 0,  0, 64'h0);
    tbl[9]  = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   1, 0,  0, 64'h0);
    tbl[10] = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   1, 0,  0, 64'h0);
    tbl[11] = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   1, 0,  0, 64'h0);
    tbl[12] = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   1, 0,  0, 64'h0);
    tbl[13] = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 0,   1, 0,  0, 64'h0);
    tbl[14] = mk(3'd1, 0, 0, 3'd0, 0,   8'h00, 1,   0, 0,  0, 64'h0);
    tbl[15] = mk(3'd1, 1, 0, 3'd3, 0,   8'h00, 0,   0, 0,  1, 64'h1);
    tbl[16] = mk(3'd1, 1, 0, 3'd4, 0,   8'h00, 0,   0, 0,  1, 64'h1);
    tbl[17] = mk(3'd0, 1, 0, 3'd0, 0,   8'h00, 0,   0, 0,  1, 64'h1);
    tbl[18] = mk(3'd0, 0, 1, 3'd1, 7,   8'h00, 0,   0, 0,  0, 64'h0);
    tbl[19] = mk(3'd0, 1, 0, 3'd1, 0,   8'h00, 0,   0, 0,  1, 64'h0);
    tbl[20] = mk(3'd0, 0, 1, 3'd0, 64'hFF, 8'h01, 0, 0, 0,  0, 64'h0);
    tbl[21] = mk(3'd0, 1, 0, 3'd0, 0,   8'h00, 0,   0, 0,  1, 64'h0);

    step();
    step();
    reset = 1'b0;
    chk("reset irq_valid", 64'(irq_valid), 64'd0);
    chk("reset readdatavalid", 64'(avmm_readdatavalid), 64'd0);
    chk("reset readdata", avmm_readdata, 64'd0);
    chk("reset irq_id", 64'(irq_id), 64'd0);

    // Cycle-by-cycle table: reset reads, masked pulse, first request with backpressure.
    for (int i = 0; i < NV; i++) begin
      irq_in          = tbl[i].irq;
      avmm_read       = tbl[i].rd;
      avmm_write      = tbl[i].wr;
      avmm_address    = tbl[i].addr;
      avmm_writedata  = tbl[i].wd;
      avmm_byteenable = tbl[i].be;
      irq_ready       = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d irq_valid", i), 64'(irq_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d irq_id", i), 64'(irq_id), 64'(tbl[i].eid));
      chk($sformatf("vec%0d readdatavalid", i), 64'(avmm_readdatavalid), 64'(tbl[i].erdv));
      if (tbl[i].erdv) chk($sformatf("vec%0d readdata", i), avmm_readdata, tbl[i].erd);
    end
    avmm_read = 1'b0; avmm_write = 1'b0; avmm_byteenable = '0; irq_ready = 1'b0;

    // All three lines together, ready held high: 0,1,2 two cycles apart, twice.
    reset = 1'b1; step(); reset = 1'b0;
    do_write(3'd1, 64'd0, 8'h01);
    irq_ready = 1'b1;
    irq_in = 3'b111;
    collect(12);
    chk_order("rr first");
    irq_in = 3'b000;
    step();
    do_write(3'd0, 64'h7, 8'h01);
    irq_in = 3'b111;
    collect(12);
    chk_order("rr wrap");

    // Held line gives one request; re-arms only after clear plus a fresh edge.
    irq_in = 3'b000;
    step();
    do_write(3'd0, 64'h7, 8'h01);
    irq_in = 3'b010;
    collect(20);
    chk("held count", 64'(got_id.size()), 64'd1);
    chk("held id", 64'((got_id.size() > 0) ? got_id[0] : -1), 64'd1);
    do_write(3'd0, 64'h2, 8'h01);
    collect(10);
    chk("cleared no edge count", 64'(got_id.size()), 64'd0);
    irq_in = 3'b000;
    step();
    irq_in = 3'b010;
    collect(10);
    chk("retoggle count", 64'(got_id.size()), 64'd1);
    chk("retoggle id", 64'((got_id.size() > 0) ? got_id[0] : -1), 64'd1);

    // Mask and clear during REQ do not retract the request.
    irq_ready = 1'b0;
    irq_in = 3'b000;
    step();
    do_write(3'd0, 64'h7, 8'h01);
    irq_in = 3'b100;
    wait_valid("line2");
    chk("line2 id", 64'(irq_id), 64'd2);
    do_write(3'd1, 64'h4, 8'h01);
    chk("masked in REQ valid", 64'(irq_valid), 64'd1);
    chk("masked in REQ id", 64'(irq_id), 64'd2);
    do_write(3'd0, 64'h4, 8'h01);
    chk("cleared in REQ valid", 64'(irq_valid), 64'd1);
    step();
    step();
    chk("hold valid", 64'(irq_valid), 64'd1);
    chk("hold id", 64'(irq_id), 64'd2);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    chk("line2 accepted valid", 64'(irq_valid), 64'd0);
    rd_chk("SENT after clear+accept", 3'd3, 64'h0);
    rd_chk("PENDING after clear+accept", 3'd0, 64'h0);
    rd_chk("REQ_COUNT", 3'd4, 64'd9);

    // Reset while a request is outstanding.
    irq_in = 3'b000;
    do_write(3'd1, 64'h0, 8'h01);
    irq_in = 3'b001;
    wait_valid("line0");
    chk("line0 id", 64'(irq_id), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset irq_valid", 64'(irq_valid), 64'd0);
    irq_in = 3'b000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_chk("post-reset MASK", 3'd1, 64'h7);
    rd_chk("post-reset PENDING", 3'd0, 64'h0);
    rd_chk("post-reset SENT", 3'd3, 64'h0);
    rd_chk("post-reset REQ_COUNT", 3'd4, 64'h0);
    chk("post-reset irq_valid", 64'(irq_valid), 64'd0);

    // Line high across reset release counts as a rise.
    irq_in = 3'b010;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rd_chk("high-at-reset PENDING", 3'd0, 64'h2);

    // Back-to-back reads: RAW then unmapped.
    irq_in = 3'b011;
    avmm_read = 1'b1;
    avmm_address = 3'd2;
    step();
    chk("b2b rdv0", 64'(avmm_readdatavalid), 64'd1);
    chk("b2b RAW", avmm_readdata, 64'h3);
    avmm_address = 3'd5;
    step();
    chk("b2b rdv1", 64'(avmm_readdatavalid), 64'd1);
    chk("b2b unmapped", avmm_readdata, 64'h0);
    avmm_read = 1'b0;
    step();
    chk("b2b rdv idle", 64'(avmm_readdatavalid), 64'd0);
    chk("waitrequest", 64'(avmm_waitrequest), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/asp_irq_ctrl.md
# asp_irq_ctrl

Interrupt controller for the ASP, downstream of the DMA_0, kernel and DMA_1 interrupt sources and upstream of the host interrupt-request port. It edge-latches each source into a pending register and applies a host-programmable mask. It issues one request per newly pending, unmasked line over a valid/ready handshake, arbitrating round-robin between lines. Status and control registers are exposed on a 64-bit MMIO AVMM slave that hangs off the board MMIO space.

## Interface
Parameters:
- NUM_IRQ, default BSP_AVMM_NUM_IRQ_USED (3): number of sources used; bit i = line i (DMA_0=0, kernel=1, DMA_1=2).
- NUM_LINES, default BSP_NUM_INTERRUPT_LINES (4): host interrupt lines; NUM_IRQ <= NUM_LINES.
- ADDR_WIDTH, default 3: AVMM 64-bit word address width.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  level-or-pulse interrupt sources, synchronous to clk.
- avmm_address  in  ADDR_WIDTH  word address.
- avmm_read  in  1  read strobe.
- avmm_write  in  1  write strobe.
- avmm_writedata  in  64  write data.
- avmm_byteenable  in  8  byte enables.
- avmm_readdata  out  64  read data.
- avmm_readdatavalid  out  1  read response strobe.
- avmm_waitrequest  out  1  constant 0.
- irq_valid  out  1  request to host.
- irq_id  out  $clog2(NUM_LINES)  line index of request.
- irq_ready  in  1  host accepts request.

## Operation
- Edge detect: irq_in_q <= irq_in each cycle. rise[i] = irq_in[i] & ~irq_in_q[i].
- pending[i] is set on rise[i]. It is cleared by a W1C write to PENDING. Set wins over clear in the same cycle.
- sent[i] is set when a request for line i is accepted. It is cleared whenever pending[i] is cleared.
- eligible = pending & ~mask & ~sent.
- FSM IDLE: if eligible != 0, grant the first eligible bit searching upward from last+1 (wrap at NUM_IRQ). Register irq_id = grant and irq_valid = 1, then go to REQ.
- FSM REQ: hold irq_valid and irq_id stable until irq_ready. On acceptance:
  - set sent[irq_id];
  - last <= irq_id;
  - req_count++ (32-bit, wraps);
  - irq_valid <= 0;
  - go to IDLE.
- A request, once issued, is never retracted. Masking or clearing the line during REQ does not drop irq_valid.
- Acceptance and clear of the same line in the same cycle: sent ends at 0 and pending ends at 0, or at 1 if a rise also occurs in that cycle.
- Register map (word address):
  - 0 PENDING W1C;
  - 1 MASK RW, 1 = masked;
  - 2 RAW RO irq_in;
  - 3 SENT RO;
  - 4 REQ_COUNT RO in [31:0].
- Bits above NUM_IRQ-1 read 0. Unmapped addresses read 0. Writes to RO or unmapped registers are ignored.
- A write acts only on bytes whose byteenable is set. Only byte 0 matters for NUM_IRQ <= 8.

## Timing
- Reset values:
  - pending, sent, irq_in_q = 0; MASK = all 1s; req_count = 0;
  - FSM IDLE; last = NUM_IRQ-1, so the first grant searches from bit 0;
  - irq_valid = 0, irq_id = 0, avmm_readdata = 0, avmm_readdatavalid = 0.
- A line already high when reset deasserts counts as a rise in the first cycle.
- Rise at cycle N: pending visible at N+1. If the line is eligible and the FSM is IDLE, irq_valid is asserted at N+2.
- Mask write at cycle N takes effect on eligibility from N+1.
- A PENDING clear at N makes the line re-requestable on its next rise.
- After acceptance at N, the next irq_valid can assert no earlier than N+2 (IDLE for one cycle).
- Reads: fixed 1-cycle latency. avmm_readdatavalid is asserted in the cycle after avmm_read and returns the register value sampled at the read cycle. Back-to-back reads are supported.
- avmm_read and avmm_write are never asserted together.
- Reset mid-REQ: irq_valid drops asynchronously. The request is lost; the host re-reads PENDING after reset.

## Structure
- The register word-address constants (PENDING/MASK/RAW/SENT/REQ_COUNT) and the FSM state enum go in dc_bsp_pkg, alongside the existing IRQ bit parameters.
- One sub-module, asp_irq_rr_arbiter: combinational round-robin select (inputs eligible and last, outputs grant index and any). Everything else stays in asp_irq_ctrl.

## Test plan
- Reset, then read MASK: 0x7; PENDING: 0; irq_valid stays 0. Pulse irq_in = 0b010: PENDING reads 0x2, no request.
- Write MASK = 0, then raise irq_in[0] at cycle N: irq_valid = 1 with irq_id = 0 at N+2. Hold irq_ready = 0 for 5 cycles: valid and id stable. Accept: SENT = 0x1, REQ_COUNT = 1.
- All three lines rise together with MASK = 0 and irq_ready always 1: ids issued 0, 1, 2 in that order, each 2 cycles apart. Clear PENDING 0x7, rise again: order 0, 1, 2 again (last = 2 wraps to 0).
- Line 1 held high continuously after its request: no second request. Write PENDING = 0x2, then toggle irq_in[1]: exactly one new request with id = 1.
- During REQ for id 2, write MASK = 0x4 and PENDING = 0x4: irq_valid holds until irq_ready. After acceptance, SENT bit 2 = 0 and PENDING bit 2 = 0.
- Assert reset while irq_valid = 1: irq_valid = 0 immediately and all registers return to reset values. Back-to-back reads of addresses 2 and 5: data valid on consecutive cycles, address 5 returns 0.
